mvau_wmem_ctrl: RTL and testbench
=================================

MVAU_WMEM_CTRL -- requirements
Module: mvau_wmem_ctrl

Interface
REQ-001 Parameter WMEM_DEPTH, default 16: number of weight words per full pass of one weight memory.
REQ-002 Parameter WMEM_ADDR_BW, default 4: address width, SHALL equal $clog2(WMEM_DEPTH) with a minimum of 1.
REQ-003 Parameter NUM_REPS, default 4: passes over the weight memory per image, one pass per output pixel.
REQ-004 Parameter REP_BW, default 2: repetition counter width, SHALL equal $clog2(NUM_REPS) with a minimum of 1.
REQ-005 clk  input  1  main clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin one image; sampled only in IDLE.
REQ-008 in_v  input  1  activation beat available to the MVAU datapath.
REQ-009 out_rdy  input  1  downstream can accept one more SIMD-lane product.
REQ-010 wmem_addr  output  WMEM_ADDR_BW  address driven to the weight memory, which has synchronous 1-cycle read latency.
REQ-011 adv  output  1  combinational accept strobe; the current address is consumed this cycle.
REQ-012 wmem_dv  output  1  weight memory output word is valid this cycle.
REQ-013 wmem_last  output  1  qualifies wmem_dv; the word is the last address of a pass.
REQ-014 rep_done  output  1  one-cycle pulse, aligned with wmem_dv, on the final word of every pass.
REQ-015 img_done  output  1  one-cycle pulse on the cycle after the final word of the last pass is valid.
REQ-016 busy  output  1  high in every state other than IDLE.

Function
REQ-017 The block SHALL implement a 3-state FSM: IDLE, RUN, DRAIN.
REQ-018 IDLE transitions: start=1 -> RUN, and the address and repetition counters SHALL clear to 0; start=0 -> remain in IDLE.
REQ-019 In RUN, adv SHALL equal in_v AND out_rdy; in every other state adv SHALL be 0.
REQ-020 The address SHALL increment by 1 on adv only; without adv it SHALL hold, so the memory output holds its word.
REQ-021 Address wrap: adv at address WMEM_DEPTH-1 SHALL set the address to 0 and increment the repetition counter.
REQ-022 Last-pass wrap: adv at address WMEM_DEPTH-1 with repetition counter NUM_REPS-1 SHALL clear both counters and move to DRAIN.
REQ-023 DRAIN transition: after exactly one cycle, the FSM SHALL move to IDLE and pulse img_done.
REQ-024 wmem_dv SHALL be adv registered one cycle; the data on wmem_dv corresponds to the address accepted in the previous cycle.
REQ-025 wmem_last and rep_done SHALL be the registered flag "adv AND address = WMEM_DEPTH-1".
REQ-026 start asserted in RUN or DRAIN SHALL be ignored, with no restart and no queuing.
REQ-027 in_v=1 with out_rdy=0 SHALL stall: address held, wmem_dv=0 on the next cycle.
REQ-028 WMEM_DEPTH=1: every adv SHALL be a wrap, and wmem_last SHALL be 1 on every valid word.
REQ-029 A new start SHALL NOT be accepted on the cycle img_done pulses, because the FSM is entering IDLE that cycle; it SHALL be accepted from the following cycle.
REQ-030 Counters SHALL never exceed WMEM_DEPTH-1 and NUM_REPS-1; no arithmetic overflow SHALL occur.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force the following:
- state IDLE;
- wmem_addr = 0 and repetition counter = 0;
- wmem_dv, wmem_last, rep_done, img_done and busy = 0.
REQ-032 Reset asserted mid-pass SHALL abandon the pass; no img_done or rep_done SHALL follow reset release.
REQ-033 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-034 Defaults, start, then in_v=out_rdy=1 held:
- addresses 0..15 repeat 4 times over 64 cycles;
- wmem_dv is high on each cycle after an adv;
- rep_done pulses 4 times;
- img_done pulses once, 2 cycles after the last adv.
REQ-035 Stall during RUN at address 5, out_rdy=0 for 3 cycles:
- wmem_addr holds 5;
- wmem_dv=0 for 3 cycles;
- on resume, the next valid word is for address 5 and none is skipped.
REQ-036 start pulsed during RUN at pass 2: no change in sequence, with exactly 64 valid words for the image.
REQ-037 rst_n dropped at pass 1, address 9:
- outputs go to 0 asynchronously, before the next clk edge;
- after release and a new start, the sequence restarts at address 0, pass 0.
REQ-038 WMEM_DEPTH=1, NUM_REPS=3: three valid words, each with wmem_last=1 and rep_done=1, then img_done.
REQ-039 start held high continuously: a second image begins one cycle after img_done, with idle gap exactly 1 cycle.

Source files
------------

// File: rtl/mvau_wmem_ctrl.sv
// Weight-memory address sequencer for an MVAU: walks WMEM_DEPTH addresses NUM_REPS times per image.
// Latency: wmem_dv/wmem_last/rep_done follow the accepting adv by one cycle; img_done arrives two cycles after the final adv.
// Backpressure: adv = in_v & out_rdy while running; without adv the address (and so the memory word) holds.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin one image (sampled only in IDLE, ignored on the img_done cycle)
//   in_v, out_rdy    activation available / downstream can accept a product
//   wmem_addr        weight memory read address (memory has 1-cycle read latency)
//   adv              combinational accept strobe for the current address
//   wmem_dv          memory output word valid (adv delayed one cycle)
//   wmem_last        qualifies wmem_dv: word came from the last address of a pass
//   rep_done         pulse with wmem_dv on the final word of every pass
//   img_done         pulse the cycle after the final word of the image is valid
//   busy             high whenever not IDLE
module mvau_wmem_ctrl #(
    parameter int WMEM_DEPTH   = 16,
    parameter int WMEM_ADDR_BW = 4,
    parameter int NUM_REPS     = 4,
    parameter int REP_BW       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_v,
    input  logic                    out_rdy,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    adv,
    output logic                    wmem_dv,
    output logic                    wmem_last,
    output logic                    rep_done,
    output logic                    img_done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    localparam logic [REP_BW-1:0]       REP_LAST  = REP_BW'(NUM_REPS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [REP_BW-1:0]       rep;
    logic [REP_BW-1:0]       rep_nxt;
    logic [WMEM_ADDR_BW-1:0] addr_nxt;
    logic                    at_last_addr;
    logic                    last_q;

    assign at_last_addr = (wmem_addr == ADDR_LAST);
    assign busy         = (state != IDLE);
    assign wmem_last    = last_q;
    assign rep_done     = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wmem_addr <= '0;
            rep       <= '0;
            wmem_dv   <= 1'b0;
            last_q    <= 1'b0;
            img_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wmem_addr <= addr_nxt;
            rep       <= rep_nxt;
            wmem_dv   <= adv;
            last_q    <= adv && at_last_addr;
            // DRAIN lasts exactly one cycle, so this is a single pulse as IDLE is entered.
            img_done  <= (state == DRAIN);
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = wmem_addr;
        rep_nxt   = rep;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                // img_done high means IDLE was only just entered; a start here is dropped.
                if (start && !img_done) begin
                    state_nxt = RUN;
                    addr_nxt  = '0;
                    rep_nxt   = '0;
                end
            end
            RUN: begin
                adv = in_v && out_rdy;
                if (adv) begin
                    if (at_last_addr) begin
                        addr_nxt = '0;
                        if (rep == REP_LAST) begin
                            rep_nxt   = '0;
                            state_nxt = DRAIN;
                        end else begin
                            rep_nxt = rep + REP_BW'(1);
                        end
                    end else begin
                        addr_nxt = wmem_addr + WMEM_ADDR_BW'(1);
                    end
                end
            end
            DRAIN: begin
                // Lets the final word's wmem_dv go out before returning to IDLE.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mvau_wmem_ctrl.sv
module tb_mvau_wmem_ctrl;

    localparam int D = 16;
    localparam int R = 4;
    localparam int N = D * R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, in_v = 1'b0, out_rdy = 1'b0;
    logic [3:0] wmem_addr;
    logic       adv, wmem_dv, wmem_last, rep_done, img_done, busy;

    // Second instance: single-word memory, three passes.
    logic       start1 = 1'b0, in1 = 1'b0, rdy1 = 1'b0;
    logic [0:0] addr1;
    logic       adv1, dv1, last1, rd1, img1, busy1;

    mvau_wmem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_v(in_v), .out_rdy(out_rdy),
        .wmem_addr(wmem_addr), .adv(adv), .wmem_dv(wmem_dv), .wmem_last(wmem_last),
        .rep_done(rep_done), .img_done(img_done), .busy(busy)
    );

    mvau_wmem_ctrl #(.WMEM_DEPTH(1), .WMEM_ADDR_BW(1), .NUM_REPS(3), .REP_BW(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_v(in1), .out_rdy(rdy1),
        .wmem_addr(addr1), .adv(adv1), .wmem_dv(dv1), .wmem_last(last1),
        .rep_done(rd1), .img_done(img1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (image = sequence of N beats) ----------------
    typedef struct {
        int addr;
        int last;
        int cyc;
    } word_t;

    word_t wq[$];      // expected valid words, stamped with the cycle they must appear
    int    img_q[$];   // cycles on which img_done must pulse
    bit    running;
    int    k;          // beats accepted in the current image
    int    t_last;     // cycle of the final beat of the most recent image
    int    cyc = 0;

    task automatic model_reset();
        running = 1'b0;
        k       = 0;
        t_last  = -10;
        wq.delete();
        img_q.delete();
    endtask

    // One clock cycle: check combinational/current outputs, then advance the model.
    task automatic cycle();
        bit acc;
        @(negedge clk);
        acc = running && in_v && out_rdy && rst_n;
        chk("adv", int'(adv), int'(acc));
        chk("wmem_addr", int'(wmem_addr), running ? (k % D) : 0);
        chk("busy", int'(busy), int'(rst_n && (running || cyc == t_last + 1)));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (acc) begin
            wq.push_back('{addr: k % D, last: int'((k % D) == D - 1), cyc: cyc + 1});
            k++;
            if (k == N) begin
                running = 1'b0;
                t_last  = cyc;
                img_q.push_back(cyc + 2);
            end
        end else if (!running && start && cyc >= t_last + 3) begin
            running = 1'b1;
            k       = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit s, input bit v, input bit r);
        start   = s;
        in_v    = v;
        out_rdy = r;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int prev_addr = 0;
    int rep_cnt = 0, img_cnt = 0, dv_cnt = 0;

    always @(negedge clk) begin
        word_t w;
        if (rst_n) begin
            chk("img_done", int'(img_done), int'(img_q.size() > 0 && img_q[0] == cyc));
            if (img_q.size() > 0 && img_q[0] <= cyc) void'(img_q.pop_front());
            if (img_done) img_cnt++;
            if (rep_done) rep_cnt++;
            if (wmem_dv) begin
                dv_cnt++;
                if (wq.size() == 0) begin
                    chk("unexpected_dv", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("dv_cycle", cyc, w.cyc);
                    chk("dv_addr", prev_addr, w.addr);
                    chk("wmem_last", int'(wmem_last), w.last);
                    chk("rep_done", int'(rep_done), w.last);
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                chk("missing_dv", 0, 1);
                void'(wq.pop_front());
            end
        end
        prev_addr = int'(wmem_addr);
    end

    // ---------------- stimulus ----------------
    int base_r, base_i, base_d;

    initial begin
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", int'(wmem_addr), 0);
        chk("rst_dv", int'(wmem_dv), 0);
        chk("rst_last", int'(wmem_last), 0);
        chk("rst_rep_done", int'(rep_done), 0);
        chk("rst_img_done", int'(img_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_busy1", int'(busy1), 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        drive(0, 1, 1);
        repeat (2) cycle();   // idle, no start: nothing may happen

        // Full-rate image: 4 passes of 16 words, img_done once.
        base_r = rep_cnt; base_i = img_cnt; base_d = dv_cnt;
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (N + 4) cycle();
        chk("full_rep_done_pulses", rep_cnt - base_r, R);
        chk("full_img_done_pulses", img_cnt - base_i, 1);
        chk("full_words", dv_cnt - base_d, N);

        // Stall at address 5 for 3 cycles.
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (5) cycle();
        drive(0, 1, 0); repeat (3) cycle();
        chk("stall_addr_held", int'(wmem_addr), 5);
        drive(0, 1, 1); repeat (N + 4) cycle();

        // Start pulsed mid-image (pass 2) is ignored.
        base_d = dv_cnt;
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (40) cycle();
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (N - 41 + 6) cycle();
        chk("restart_ignored_words", dv_cnt - base_d, N);

        // Reset at pass 1, address 9: asynchronous clear, then clean restart.
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (D + 9) cycle();
        chk("pre_reset_addr", int'(wmem_addr), 9);
        drive(0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_addr", int'(wmem_addr), 0);
        chk("async_dv", int'(wmem_dv), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_rep_done", int'(rep_done), 0);
        repeat (2) cycle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        base_i = img_cnt;
        drive(0, 1, 1); repeat (4) cycle();
        chk("no_img_after_reset", img_cnt - base_i, 0);
        drive(1, 1, 1); cycle();
        drive(0, 1, 1); repeat (N + 4) cycle();

        // Start held high: back-to-back images with the img_done cycle blocking start.
        drive(1, 1, 1); repeat (2 * N + 10) cycle();
        drive(0, 1, 1); repeat (N + 6) cycle();

        // Randomized traffic with sporadic start pulses.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
            cycle();
        end
        drive(0, 1, 1); repeat (N + 6) cycle();
        chk("queue_empty_words", wq.size(), 0);
        chk("queue_empty_img", img_q.size(), 0);
        chk("idle_at_end", int'(busy), 0);

        // Depth 1, three passes, one stall cycle.
        for (int c = 0; c < 9; c++) begin
            start1 = (c == 0);
            in1    = 1'b1;
            rdy1   = (c != 2);
            @(negedge clk);
            chk("d1_dv", int'(dv1), int'(c == 2 || c == 4 || c == 5));
            chk("d1_last", int'(last1), int'(c == 2 || c == 4 || c == 5));
            chk("d1_rep_done", int'(rd1), int'(c == 2 || c == 4 || c == 5));
            chk("d1_img_done", int'(img1), int'(c == 6));
            chk("d1_busy", int'(busy1), int'(c >= 1 && c <= 5));
            chk("d1_addr", int'(addr1), 0);
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
